// File: rtl/dcache_pkg.sv
// Shared types, default geometry and address-split helpers for the data cache.
package dcache_pkg;

    localparam int unsigned DefNumLines  = 32;
    localparam int unsigned DefLineBytes = 32;

    typedef enum logic [1:0] {
        StIdle,
        StWriteback,
        StAllocate,
        StRetry
    } dcache_state_e;

    // Helpers return 64-bit values; callers size-cast to the field width they need.
    function automatic logic [63:0] addr_index(input logic [63:0] addr,
                                               input int unsigned num_lines,
                                               input int unsigned line_bytes);
        return (addr >> $clog2(line_bytes)) & (64'(num_lines) - 64'd1);
    endfunction

    function automatic logic [63:0] addr_tag(input logic [63:0] addr,
                                             input int unsigned num_lines,
                                             input int unsigned line_bytes);
        return addr >> ($clog2(line_bytes) + $clog2(num_lines));
    endfunction

    function automatic logic [63:0] addr_word(input logic [63:0] addr,
                                              input int unsigned line_bytes);
        return (addr >> 2) & (64'(line_bytes / 4) - 64'd1);
    endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data arrays: combinational read, synchronous write.
// Only valid and dirty are cleared by reset.
module dcache_sram
    import dcache_pkg::*;
#(
    parameter int unsigned NUM_LINES  = DefNumLines,
    parameter int unsigned LINE_BYTES = DefLineBytes,
    parameter int unsigned TAG_W      = 22
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [$clog2(NUM_LINES)-1:0]      idx_i,
    output logic                              valid_o,
    output logic                              dirty_o,
    output logic [TAG_W-1:0]                  tag_o,
    output logic [8*LINE_BYTES-1:0]           line_o,
    input  logic                              fill_i,
    input  logic [TAG_W-1:0]                  fill_tag_i,
    input  logic [8*LINE_BYTES-1:0]           fill_line_i,
    input  logic                              word_we_i,
    input  logic [$clog2(LINE_BYTES/4)-1:0]   word_sel_i,
    input  logic [31:0]                       word_i,
    input  logic                              clr_dirty_i
);

    logic [NUM_LINES-1:0]      valid_q;
    logic [NUM_LINES-1:0]      dirty_q;
    logic [TAG_W-1:0]          tag_q  [NUM_LINES];
    logic [8*LINE_BYTES-1:0]   data_q [NUM_LINES];

    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign line_o  = data_q[idx_i];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
        end else if (word_we_i) begin
            dirty_q[idx_i] <= 1'b1;
        end else if (clr_dirty_i) begin
            dirty_q[idx_i] <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (fill_i) begin
            tag_q[idx_i]  <= fill_tag_i;
            data_q[idx_i] <= fill_line_i;
        end else if (word_we_i) begin
            data_q[idx_i][32*word_sel_i +: 32] <= word_i;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate MEM-stage data cache controller.
// Defining DCACHE_STATS_EN adds saturating hit_cnt_o / miss_cnt_o counters.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int unsigned NUM_LINES  = DefNumLines,
    parameter int unsigned LINE_BYTES = DefLineBytes,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cpu_req_i,
    input  logic                      cpu_write_i,
    input  logic [ADDR_W-1:0]         cpu_addr_i,
    input  logic [31:0]               cpu_wdata_i,
    output logic [31:0]               cpu_rdata_o,
    output logic                      cpu_stall_o,
    output logic                      mem_req_o,
    output logic                      mem_write_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    output logic [8*LINE_BYTES-1:0]   mem_wdata_o,
    input  logic [8*LINE_BYTES-1:0]   mem_rdata_i,
    input  logic                      mem_ack_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]               hit_cnt_o,
    output logic [31:0]               miss_cnt_o
`endif
);

    localparam int unsigned OffW  = $clog2(LINE_BYTES);
    localparam int unsigned IdxW  = $clog2(NUM_LINES);
    localparam int unsigned TagW  = ADDR_W - OffW - IdxW;
    localparam int unsigned WordW = $clog2(LINE_BYTES / 4);
    localparam int unsigned LW    = 8 * LINE_BYTES;

    dcache_state_e     state_q, state_d;
    logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
    logic              lat_write_q, lat_write_d;
    logic [31:0]       lat_wdata_q, lat_wdata_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LW-1:0]     mem_wdata_q, mem_wdata_d;

    logic [ADDR_W-1:0] lk_addr;
    logic [IdxW-1:0]   lk_idx;
    logic [TagW-1:0]   lk_tag;
    logic [WordW-1:0]  lk_word;
    logic              rd_valid, rd_dirty;
    logic [TagW-1:0]   rd_tag;
    logic [LW-1:0]     rd_line;
    logic              hit, st_we, fill, clr_dirty;
    logic [31:0]       st_wdata;

    // Outside IDLE the lookup follows the access latched at miss detection.
    assign lk_addr = (state_q == StIdle) ? cpu_addr_i : lat_addr_q;
    assign lk_idx  = IdxW'(addr_index(64'(lk_addr), NUM_LINES, LINE_BYTES));
    assign lk_tag  = TagW'(addr_tag(64'(lk_addr), NUM_LINES, LINE_BYTES));
    assign lk_word = WordW'(addr_word(64'(lk_addr), LINE_BYTES));

    assign hit         = cpu_req_i & rd_valid & (rd_tag == lk_tag);
    assign cpu_stall_o = cpu_req_i & ~hit;
    assign cpu_rdata_o = rd_line[32*lk_word +: 32];
    assign st_we       = hit & ((state_q == StIdle) ? cpu_write_i : lat_write_q);
    assign st_wdata    = (state_q == StIdle) ? cpu_wdata_i : lat_wdata_q;

    dcache_sram #(
        .NUM_LINES  (NUM_LINES),
        .LINE_BYTES (LINE_BYTES),
        .TAG_W      (TagW)
    ) u_sram (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .idx_i       (lk_idx),
        .valid_o     (rd_valid),
        .dirty_o     (rd_dirty),
        .tag_o       (rd_tag),
        .line_o      (rd_line),
        .fill_i      (fill),
        .fill_tag_i  (lk_tag),
        .fill_line_i (mem_rdata_i),
        .word_we_i   (st_we),
        .word_sel_i  (lk_word),
        .word_i      (st_wdata),
        .clr_dirty_i (clr_dirty)
    );

    always_comb begin
        state_d     = state_q;
        lat_addr_d  = lat_addr_q;
        lat_write_d = lat_write_q;
        lat_wdata_d = lat_wdata_q;
        mem_req_d   = mem_req_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        fill        = 1'b0;
        clr_dirty   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cpu_req_i && !hit) begin
                    lat_addr_d  = cpu_addr_i;
                    lat_write_d = cpu_write_i;
                    lat_wdata_d = cpu_wdata_i;
                    mem_req_d   = 1'b1;
                    if (rd_valid && rd_dirty) begin
                        state_d     = StWriteback;
                        mem_write_d = 1'b1;
                        mem_addr_d  = {rd_tag, lk_idx, {OffW{1'b0}}};
                        mem_wdata_d = rd_line;
                    end else begin
                        state_d     = StAllocate;
                        mem_write_d = 1'b0;
                        mem_addr_d  = {lk_tag, lk_idx, {OffW{1'b0}}};
                    end
                end
            end
            StWriteback: begin
                if (mem_req_q && mem_ack_i) begin
                    clr_dirty   = 1'b1;
                    mem_req_d   = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = StAllocate;
                end
            end
            StAllocate: begin
                // Arriving from write-back the request is re-raised after one idle cycle.
                if (!mem_req_q) begin
                    mem_req_d   = 1'b1;
                    mem_write_d = 1'b0;
                    mem_addr_d  = {lk_tag, lk_idx, {OffW{1'b0}}};
                end else if (mem_ack_i) begin
                    fill      = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = StRetry;
                end
            end
            StRetry: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            lat_addr_q  <= '0;
            lat_write_q <= 1'b0;
            lat_wdata_q <= '0;
            mem_req_q   <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            lat_addr_q  <= lat_addr_d;
            lat_write_q <= lat_write_d;
            lat_wdata_q <= lat_wdata_d;
            mem_req_q   <= mem_req_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_write_o = mem_write_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

`ifdef DCACHE_STATS_EN
    logic        miss_start;
    logic [31:0] hit_cnt_q, miss_cnt_q;

    assign miss_start = (state_q == StIdle) & cpu_req_i & ~hit;

    // Retry-cycle hits belong to the miss already counted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit && state_q == StIdle && hit_cnt_q != '1) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (miss_start && miss_cnt_q != '1) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Randomized self-checking bench for dcache_ctrl against a line-level cache/memory model.
module tb_dcache_ctrl;

    localparam int NL = 32;
    localparam int LB = 32;
    localparam int LW = 8 * LB;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          cpu_req_i, cpu_write_i;
    logic [31:0]   cpu_addr_i, cpu_wdata_i, cpu_rdata_o;
    logic          cpu_stall_o, mem_req_o, mem_write_o, mem_ack_i;
    logic [31:0]   mem_addr_o;
    logic [LW-1:0] mem_wdata_o, mem_rdata_i;
`ifdef DCACHE_STATS_EN
    logic [31:0]   hit_cnt_o, miss_cnt_o;
`endif

    always #5 clk = ~clk;

    dcache_ctrl #(
        .NUM_LINES  (NL),
        .LINE_BYTES (LB),
        .ADDR_W     (32)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .cpu_req_i   (cpu_req_i),
        .cpu_write_i (cpu_write_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_wdata_i (cpu_wdata_i),
        .cpu_rdata_o (cpu_rdata_o),
        .cpu_stall_o (cpu_stall_o),
        .mem_req_o   (mem_req_o),
        .mem_write_o (mem_write_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt_o   (hit_cnt_o),
        .miss_cnt_o  (miss_cnt_o)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference: cache contents per line plus a sparse backing memory.
    logic          m_valid [NL];
    logic          m_dirty [NL];
    logic [31:0]   m_tag   [NL];
    logic [LW-1:0] m_line  [NL];
    logic [LW-1:0] ref_mem [logic [31:0]];
    int            m_hits, m_misses;

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [LW-1:0] mem_line(input logic [31:0] la);
        logic [LW-1:0] l;
        if (ref_mem.exists(la)) return ref_mem[la];
        for (int i = 0; i < LB / 4; i++) l[i*32 +: 32] = la ^ (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
        return l;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NL; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        m_hits   = 0;
        m_misses = 0;
    endtask

    // One CPU access; acts as memory (ack lat+1 cycles after each request rises).
    // drop_at > 0 drops cpu_req_i after that many stalled cycles.
    task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input int lat, input int drop_at);
        int            idx, word, nstall, cyc, cnt;
        logic [31:0]   tag, la, victim;
        logic          hit, wb, prev_req, filled, req_live;
        logic [LW-1:0] line;
        logic [31:0]   rq_addr[$];
        logic          rq_write[$];
        logic [LW-1:0] rq_wdata[$];
        idx  = int'((addr / LB) % NL);
        word = int'((addr % LB) / 4);
        tag  = addr / (LB * NL);
        la   = addr - addr % LB;
        hit  = m_valid[idx] && (m_tag[idx] == tag);
        @(negedge clk);
        cpu_req_i = 1'b1; cpu_write_i = wr; cpu_addr_i = addr; cpu_wdata_i = wd; mem_ack_i = 1'b0;
        #1;
        check("stall_first", cpu_stall_o, !hit);
        if (hit) begin
            m_hits++;
            check("hit_no_mem_req", mem_req_o, 1'b0);
            if (!wr) check("hit_rdata", cpu_rdata_o, m_line[idx][word*32 +: 32]);
            else begin
                m_line[idx][word*32 +: 32] = wd;
                m_dirty[idx] = 1'b1;
            end
            return;
        end
        m_misses++;
        wb = m_valid[idx] && m_dirty[idx];
        victim = m_tag[idx] * 32'(LB * NL) + 32'(idx * LB);
        nstall = 0; cyc = 0; cnt = 0; prev_req = 1'b0; filled = 1'b0; req_live = 1'b1;
        forever begin
            if (filled) begin
                if (req_live) begin
                    check("retry_stall", cpu_stall_o, 1'b0);
                    line = mem_line(la);
                    if (!wr) check("retry_rdata", cpu_rdata_o, line[word*32 +: 32]);
                end
                break;
            end
            if (req_live && cpu_stall_o) nstall++;
            if (mem_req_o && prev_req) check("req_addr_stable", mem_addr_o, rq_addr[$]);
            if (mem_req_o && !prev_req) begin
                rq_addr.push_back(mem_addr_o);
                rq_write.push_back(mem_write_o);
                rq_wdata.push_back(mem_wdata_o);
                cnt = 0;
            end
            prev_req = mem_req_o;
            if (mem_req_o) begin
                cnt++;
                if (cnt == lat + 1) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = mem_line(mem_addr_o);
                    if (!mem_write_o) filled = 1'b1;
                end
            end
            cyc++;
            if (cyc == drop_at) begin
                cpu_req_i = 1'b0;
                req_live  = 1'b0;
            end
            if (cyc > 500) begin
                check("miss_timeout", filled, 1'b1);
                break;
            end
            @(negedge clk);
            mem_ack_i = 1'b0;
            #1;
        end
        if (wb) begin
            check("req_count_wb", rq_addr.size(), 2);
            if (rq_addr.size() == 2) begin
                check("wb_write", rq_write[0], 1'b1);
                check("wb_addr", rq_addr[0], victim);
                check("wb_data", rq_wdata[0], m_line[idx]);
                check("fill_write", rq_write[1], 1'b0);
                check("fill_addr", rq_addr[1], la);
            end
            ref_mem[victim] = m_line[idx];
        end else begin
            check("req_count", rq_addr.size(), 1);
            if (rq_addr.size() >= 1) begin
                check("fill_write", rq_write[0], 1'b0);
                check("fill_addr", rq_addr[0], la);
            end
        end
        if (drop_at == 0) check("stall_cycles", nstall, wb ? 2 * lat + 4 : lat + 2);
        m_valid[idx] = 1'b1;
        m_dirty[idx] = 1'b0;
        m_tag[idx]   = tag;
        m_line[idx]  = mem_line(la);
        if (wr && req_live) begin
            m_line[idx][word*32 +: 32] = wd;
            m_dirty[idx] = 1'b1;
        end
    endtask

    task automatic idle_cycle(input logic spurious);
        @(negedge clk);
        cpu_req_i = 1'b0;
        mem_ack_i = spurious;
        #1;
        check("idle_stall", cpu_stall_o, 1'b0);
        check("idle_req", mem_req_o, 1'b0);
        @(negedge clk);
        mem_ack_i = 1'b0;
        #1;
        check("idle_req_after_ack", mem_req_o, 1'b0);
    endtask

    task automatic check_stats();
`ifdef DCACHE_STATS_EN
        check("hit_cnt", hit_cnt_o, m_hits);
        check("miss_cnt", miss_cnt_o, m_misses);
`endif
    endtask

    initial begin
        logic [LW-1:0] l40;
        rst_i = 1'b1; cpu_req_i = 1'b0; cpu_write_i = 1'b0; cpu_addr_i = '0; cpu_wdata_i = '0;
        mem_ack_i = 1'b0; mem_rdata_i = '0;
        model_reset();
        l40 = mem_line(32'h40);
        l40[31:0] = 32'h1122_3344;
        ref_mem[32'h40] = l40;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        check("rst_mem_req", mem_req_o, 1'b0);
        check("rst_mem_write", mem_write_o, 1'b0);
        check("rst_mem_addr", mem_addr_o, 32'h0);
        check("rst_mem_wdata", mem_wdata_o, '0);
        check("rst_stall_idle", cpu_stall_o, 1'b0);
        cpu_req_i = 1'b1; cpu_addr_i = 32'h40;
        #1;
        check("rst_stall_req", cpu_stall_o, 1'b1);
        cpu_req_i = 1'b0;

        access(1'b0, 32'h40, 32'h0, 10, 0);
        access(1'b0, 32'h40, 32'h0, 10, 0);
        access(1'b1, 32'h44, 32'hDEAD_BEEF, 3, 0);
        access(1'b0, 32'h44, 32'h0, 3, 0);
        access(1'b0, 32'h440, 32'h0, 3, 0);
        idle_cycle(1'b1);
        access(1'b1, 32'h80, 32'hCAFE_F00D, 4, 3);
        access(1'b0, 32'h80, 32'h0, 4, 0);
        check_stats();

        // Reset while a write-back is in flight.
        access(1'b1, 32'h448, 32'h1234_5678, 2, 0);
        @(negedge clk);
        cpu_req_i = 1'b1; cpu_write_i = 1'b0; cpu_addr_i = 32'h40;
        #1;
        for (int i = 0; i < 5 && !mem_req_o; i++) begin
            @(negedge clk);
            #1;
        end
        check("wb_started", mem_req_o && mem_write_o, 1'b1);
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        check("rst_wb_req", mem_req_o, 1'b0);
        check("rst_wb_stall", cpu_stall_o, 1'b1);
        cpu_req_i = 1'b0;
        model_reset();
        access(1'b0, 32'h40, 32'h0, 3, 0);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 5)
              | (32'($urandom_range(0, 7)) << 2);
            access(1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 5)), 0);
            if ($urandom_range(0, 9) == 0) idle_cycle(1'($urandom_range(0, 1)));
        end
        idle_cycle(1'b0);
        check_stats();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
